// File: rtl/fetch_queue.sv
// Fetch stage: in-order imem requests, registered FIFO of {inst, pc}; rvalid -> inst_valid next cycle.
// Backpressure: issue stops once queued + in-flight words would exceed DEPTH; redirect flushes and drops stale responses.
module fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUT);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    logic          rst_q;
    logic [63:0]   fetch_pc;
    logic [63:0]   resp_pc;
    logic [31:0]   inst_mem [DEPTH];
    logic [63:0]   pc_mem   [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   inflight;
    logic          empty;
    logic          issue;
    logic          rsp;
    logic          push;
    logic          pop;

    assign empty    = (count == '0);
    assign inflight = {1'b0, count} + {1'b0, outstanding};

    assign imem_req  = !rst && !rst_q && !redirect_valid &&
                       (outstanding < MAX_C) && (inflight < DEPTH_C);
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error; it is ignored.
    assign rsp  = imem_rvalid && (outstanding != '0);
    assign push = rsp && (drop_cnt == '0) && !redirect_valid;

    assign inst_valid = !rst && !empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign inst       = empty ? 32'h0 : inst_mem[rd_ptr];
    assign inst_pc    = empty ? 64'h0 : pc_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q       <= 1'b1;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            rst_q       <= 1'b0;
            outstanding <= outstanding + CW'(issue) - CW'(rsp);
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop_cnt <= outstanding - CW'(rsp);
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 64'd4;
                if (rsp && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    resp_pc <= resp_pc + 64'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: two instances (RESET_PC 0 and near-wrap) behind a delay-line memory model.
module tb_fetch_queue;
    localparam logic [63:0] BPC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect_valid, gnt, ready, inj;
    logic [63:0] redirect_pc;
    int          lat;
    int          checks = 0;
    int          errors = 0;

    logic        req_a, rvalid_a, valid_a, req_b, rvalid_b, valid_b;
    logic [63:0] addr_a, pc_a, addr_b, pc_b;
    logic [31:0] rdata_a, inst_a, rdata_b, inst_b;

    // Memory model: word at byte address x is x>>2, returned 1 or 2 cycles after grant.
    logic        p1v_a, p2v_a, p1v_b, p2v_b;
    logic [63:0] p1a_a, p2a_a, p1a_b, p2a_b, sel_a, sel_b;
    always @(posedge clk) begin
        p1v_a <= req_a && gnt;  p1a_a <= addr_a;  p2v_a <= p1v_a;  p2a_a <= p1a_a;
        p1v_b <= req_b && gnt;  p1a_b <= addr_b;  p2v_b <= p1v_b;  p2a_b <= p1a_b;
    end
    assign sel_a    = (lat == 1) ? p1a_a : p2a_a;
    assign sel_b    = (lat == 1) ? p1a_b : p2a_b;
    assign rvalid_a = ((lat == 1) ? p1v_a : p2v_a) | inj;
    assign rvalid_b = ((lat == 1) ? p1v_b : p2v_b) | inj;
    assign rdata_a  = inj ? 32'hDEAD_BEEF : sel_a[33:2];
    assign rdata_b  = inj ? 32'hDEAD_BEEF : sel_b[33:2];

    fetch_queue #(.RESET_PC(64'h0), .DEPTH(4), .MAX_OUT(2)) dut_a (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req_a), .imem_addr(addr_a), .imem_gnt(gnt), .imem_rvalid(rvalid_a),
        .imem_rdata(rdata_a), .inst_valid(valid_a), .inst_ready(ready), .inst(inst_a),
        .inst_pc(pc_a));

    fetch_queue #(.RESET_PC(BPC), .DEPTH(4), .MAX_OUT(2)) dut_b (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(gnt), .imem_rvalid(rvalid_b),
        .imem_rdata(rdata_b), .inst_valid(valid_b), .inst_ready(ready), .inst(inst_b),
        .inst_pc(pc_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle with rst low (registered reset still high).
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [63:0] e;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
        gnt = 1'b1; ready = 1'b1; lat = 1; inj = 1'b0;
        tick();
        tick();
        chk("rst_req", 64'(req_a), 64'h0);
        chk("rst_valid", 64'(valid_a), 64'h0);
        chk("rst_inst", 64'(inst_a), 64'h0);
        chk("rst_pc", pc_a, 64'h0);
        chk("rst_addr", addr_a, 64'h0);
        chk("rst_addr_b", addr_b, BPC);

        // Streaming fill and steady state; instance b wraps past 2^64.
        rst = 1'b0;
        #1;
        chk("s1_req_rstq", 64'(req_a), 64'h0);
        tick();
        chk("s1_req", 64'(req_a), 64'h1);
        chk("s1_addr0", addr_a, 64'h0);
        tick();
        chk("s1_fill_valid", 64'(valid_a), 64'h0);
        chk("s1_addr1", addr_a, 64'h4);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s1_valid", 64'(valid_a), 64'h1);
            chk("s1_pc", pc_a, 64'(4 * i));
            chk("s1_inst", 64'(inst_a), 64'(i));
            e = BPC + 64'(4 * i);
            chk("s5_pc_b", pc_b, e);
            chk("s5_inst_b", 64'(inst_b), 64'(e[33:2]));
        end

        // Decode stalled: FIFO fills to DEPTH and issue stops.
        ready = 1'b0;
        do_reset();
        repeat (20) tick();
        chk("s2_full_valid", 64'(valid_a), 64'h1);
        chk("s2_full_pc", pc_a, 64'h0);
        chk("s2_full_req", 64'(req_a), 64'h0);
        chk("s2_full_addr", addr_a, 64'h10);
        ready = 1'b1;
        #1;
        for (int j = 0; j < 6; j++) begin
            chk("s2_valid", 64'(valid_a), 64'h1);
            chk("s2_pc", pc_a, 64'(4 * j));
            chk("s2_inst", 64'(inst_a), 64'(j));
            if (j == 1) begin
                chk("s2_resume_req", 64'(req_a), 64'h1);
                chk("s2_resume_addr", addr_a, 64'h10);
            end
            tick();
        end

        // Grant withheld: address and PC hold.
        gnt = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("s3_req", 64'(req_a), 64'h1);
            chk("s3_addr", addr_a, 64'h24);
            tick();
        end
        gnt = 1'b1;
        #1;
        chk("s3_addr_gnt", addr_a, 64'h24);
        tick();
        chk("s3_empty", 64'(valid_a), 64'h0);
        tick();
        chk("s3_valid", 64'(valid_a), 64'h1);
        chk("s3_pc", pc_a, 64'h24);
        chk("s3_inst", 64'(inst_a), 64'h9);

        // Redirect with two requests in flight.
        lat = 2;
        ready = 1'b0;
        do_reset();
        repeat (6) tick();
        chk("s4_pre_valid", 64'(valid_a), 64'h1);
        chk("s4_pre_pc", pc_a, 64'h0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        #1;
        chk("s4_redir_valid", 64'(valid_a), 64'h0);
        chk("s4_redir_req", 64'(req_a), 64'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("s4_flush_valid", 64'(valid_a), 64'h0);
        chk("s4_req", 64'(req_a), 64'h1);
        chk("s4_addr", addr_a, 64'h100);
        ready = 1'b1;
        tick();
        chk("s4_drop_valid", 64'(valid_a), 64'h0);
        chk("s4_addr2", addr_a, 64'h104);
        tick();
        chk("s4_wait_valid", 64'(valid_a), 64'h0);
        tick();
        chk("s4_valid", 64'(valid_a), 64'h1);
        chk("s4_pc", pc_a, 64'h100);
        chk("s4_inst", 64'(inst_a), 64'h40);
        tick();
        chk("s4_pc2", pc_a, 64'h104);
        chk("s4_inst2", 64'(inst_a), 64'h41);

        // Reset with a full FIFO, then a stray response right after reset.
        ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("s6_full_valid", 64'(valid_a), 64'h1);
        chk("s6_full_req", 64'(req_a), 64'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inj = 1'b1;
        #1;
        chk("s6_valid", 64'(valid_a), 64'h0);
        chk("s6_req", 64'(req_a), 64'h0);
        chk("s6_inst", 64'(inst_a), 64'h0);
        chk("s6_pc", pc_a, 64'h0);
        tick();
        inj = 1'b0;
        #1;
        chk("s6_stray_valid", 64'(valid_a), 64'h0);
        chk("s6_restart_req", 64'(req_a), 64'h1);
        chk("s6_restart_addr", addr_a, 64'h0);
        ready = 1'b1;
        tick();
        chk("s6_wait1", 64'(valid_a), 64'h0);
        tick();
        chk("s6_wait2", 64'(valid_a), 64'h0);
        tick();
        chk("s6_valid1", 64'(valid_a), 64'h1);
        chk("s6_pc1", pc_a, 64'h0);
        chk("s6_inst1", 64'(inst_a), 64'h0);
        tick();
        chk("s6_pc2", pc_a, 64'h4);
        chk("s6_inst2", 64'(inst_a), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
